cache_fill_arbiter: RTL
=======================

Name: cache_fill_arbiter

Overview:
- Arbitrates the single shared main-memory port between three requesters: I-cache block fills, D-cache block fills and D-cache write-through stores.
- Sits between the two cache controllers and the multi-cycle, pipelined data memory.
- Sequences 8-word burst fills and steers returning words into the owning cache array.
- Asserts busy while a transaction is in progress; the hazard/stall logic holds the pipeline on it.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS, 8, words per cache block (power of 2)
- MEM_LATENCY, 4, cycles from mem_en issue to mem_rvalid (informational; returns are counted, not timed)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache fill request, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss address
- d_miss  in  1  D-cache fill request, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss address
- d_wr  in  1  D-cache write-through store request, held until d_wr_done
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- mem_en  out  1  memory request valid
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid
- fill_data  out  DATA_W  equals mem_rdata (combinational pass-through)
- fill_word  out  log2(WORDS)  word index of the current return
- i_fill_we  out  1  I-cache array write strobe
- d_fill_we  out  1  D-cache array write strobe
- i_fill_done  out  1  one-cycle pulse: I fill complete
- d_fill_done  out  1  one-cycle pulse: D fill complete
- d_wr_done  out  1  one-cycle pulse: store issued
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WRITE, FILL, DONE.
- Target register tgt selects I or D for the current fill.
- Counters: iss_cnt (words issued) and rcv_cnt (words received), each log2(WORDS)+1 bits.
- Reset (asynchronous, rst_n=0):
  - state = IDLE; counters and tgt = 0.
  - All outputs 0, except fill_data, which follows mem_rdata.
  - Reset mid-fill abandons the transaction; any later mem_rvalid is ignored.
- IDLE, fixed priority d_wr > d_miss > i_miss. On a grant:
  - Latch the address with the low log2(WORDS)+1 bits forced to 0 for fills; store address latched unmodified.
  - d_wr -> WRITE; d_miss/i_miss -> FILL with tgt set.
- WRITE (one cycle):
  - mem_en=1, mem_wr=1, mem_addr/mem_wdata from the latched store.
  - Next state DONE; d_wr_done=1 in that DONE cycle.
- FILL, issue side:
  - While iss_cnt < WORDS: mem_en=1, mem_wr=0, mem_addr = base + 2*iss_cnt; iss_cnt increments.
  - Issues are one per consecutive cycle, starting the first FILL cycle.
- FILL, return side:
  - On mem_rvalid: fill_word = rcv_cnt[log2(WORDS)-1:0]; the we of tgt = 1; rcv_cnt increments.
  - The last return (rcv_cnt == WORDS-1) moves the state to DONE.
- DONE (one cycle):
  - Pulse the matching done output.
  - No grant is made this cycle; arbitration resumes the following cycle, so requesters can drop their request first.
- Latency: an idle i_miss grant at cycle 0 gives FILL at 1, issues at 1..8, fill_we at 1+L..8+L and done at 9+L (13 when L=4).
- Request deassertion mid-transaction is ignored; the transaction completes.
- mem_rvalid in IDLE, WRITE or DONE is ignored: no we strobe, no counter change.
- mem_rvalid in the same cycle as an issue is handled independently; both counters update.
- Address wrap: base + 2*i wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: CACHE_FILL_ARB_RR_EN.
- Defined:
  - d_miss vs i_miss arbitration is round-robin; a last_fill flag records the target of the previous fill.
  - When both are pending, the target not served last wins.
  - d_wr keeps absolute priority.
  - last_fill resets to I, so the D side wins the first tie.
- Undefined: fixed priority d_wr > d_miss > i_miss; last_fill is not instantiated.

Test Plan:
- i_miss=1, addr 0x1236, L=4 -> mem_addr 0x1230..0x123E on cycles 1..8; i_fill_we cycles 5..12 with fill_word 0..7; i_fill_done at cycle 13 only; d_fill_we never asserted.
- d_wr=1, addr 0x0040, data 0xBEEF -> one cycle mem_en=1, mem_wr=1 with 0x0040/0xBEEF; d_wr_done next cycle; busy high for exactly 2 cycles.
- d_wr, d_miss and i_miss all asserted at cycle 0 -> order WRITE, D fill, I fill; no grant in any DONE cycle; I fill issues begin only after d_fill_done +1.
- rst_n pulsed low at cycle 6 of a fill -> all outputs 0 immediately; subsequent mem_rvalid pulses produce no fill_we; a new i_miss is served from word 0.
- Spurious mem_rvalid in IDLE, plus address 0xFFF0 fill -> no we on the spurious return; issued addresses 0xFFF0..0xFFFE.
- With CACHE_FILL_ARB_RR_EN, d_miss and i_miss held continuously -> fills alternate D, I, D, I; without the macro -> D fill repeats while d_miss is held.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// Shared memory-port arbiter: I/D block fills (8-word bursts) and D write-through stores.
// Optional macro CACHE_FILL_ARB_RR_EN: round-robin between D and I fills (stores keep priority).
module cache_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WORDS       = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_miss,
  input  logic [ADDR_W-1:0]          i_miss_addr,
  input  logic                       d_miss,
  input  logic [ADDR_W-1:0]          d_miss_addr,
  input  logic                       d_wr,
  input  logic [ADDR_W-1:0]          d_wr_addr,
  input  logic [DATA_W-1:0]          d_wr_data,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_rvalid,
  output logic [DATA_W-1:0]          fill_data,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic                       i_fill_we,
  output logic                       d_fill_we,
  output logic                       i_fill_done,
  output logic                       d_fill_done,
  output logic                       d_wr_done,
  output logic                       busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] IssueLimit = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LastWord   = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] FillMask  = {{(ADDR_W-CNT_W){1'b1}}, {CNT_W{1'b0}}};

  if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || MEM_LATENCY < 1) begin : gParamCheck
    $error("cache_fill_arbiter: WORDS must be a power of 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} stateT;

  stateT state, stateNext;
  logic [ADDR_W-1:0] baseAddr;
  logic [DATA_W-1:0] wrData;
  logic              tgt;       // 1 = D-cache fill, 0 = I-cache fill
  logic              isWrite;
  logic [CNT_W-1:0]  issCnt, rcvCnt;
  logic              grantD, grantI;
  logic [ADDR_W-1:0] fillAddr;

  assign fill_data = mem_rdata;
  assign fillAddr  = grantD ? d_miss_addr : i_miss_addr;

`ifdef CACHE_FILL_ARB_RR_EN
  logic lastFill;  // target of the previous fill, 1 = D

  always_comb begin
    grantD = !d_wr && d_miss && (!i_miss || !lastFill);
    grantI = !d_wr && i_miss && !grantD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lastFill <= 1'b0;
    else if (state == IDLE && (grantD || grantI))
      lastFill <= grantD;
  end
`else
  always_comb begin
    grantD = !d_wr && d_miss;
    grantI = !d_wr && !d_miss && i_miss;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (d_wr) stateNext = WRITE;
             else if (grantD || grantI) stateNext = FILL;
      WRITE: stateNext = DONE;
      FILL:  if (mem_rvalid && rcvCnt == LastWord) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Transaction context is captured at grant; counters restart with every new fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baseAddr <= '0;
      wrData   <= '0;
      tgt      <= 1'b0;
      isWrite  <= 1'b0;
      issCnt   <= '0;
      rcvCnt   <= '0;
    end else begin
      if (state == IDLE) begin
        if (d_wr) begin
          baseAddr <= d_wr_addr;
          wrData   <= d_wr_data;
          isWrite  <= 1'b1;
        end else if (grantD || grantI) begin
          baseAddr <= fillAddr & FillMask;
          tgt      <= grantD;
          isWrite  <= 1'b0;
          issCnt   <= '0;
          rcvCnt   <= '0;
        end
      end else if (state == FILL) begin
        if (issCnt < IssueLimit)
          issCnt <= issCnt + 1'b1;
        if (mem_rvalid)
          rcvCnt <= rcvCnt + 1'b1;
      end
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = baseAddr;
        mem_wdata = wrData;
      end
      FILL: begin
        if (issCnt < IssueLimit) begin
          mem_en   = 1'b1;
          mem_addr = baseAddr + ADDR_W'({issCnt, 1'b0});
        end
        if (mem_rvalid) begin
          fill_word = rcvCnt[IDX_W-1:0];
          i_fill_we = !tgt;
          d_fill_we = tgt;
        end
      end
      DONE: begin
        d_wr_done   = isWrite;
        d_fill_done = !isWrite && tgt;
        i_fill_done = !isWrite && !tgt;
      end
      default: ;
    endcase
  end

endmodule
